// File: rtl/drive_pkg.sv
`default_nettype none
// ============================================================================
// Module      : drive_pkg
// Description : Shared types and helpers for the drive virtual-Z phase path:
//               default phase word type, accumulator FSM states, and the
//               qubit-count / field-shift derivations.
// Revision    : 1.0 - initial release
// ============================================================================
package drive_pkg;

    // Default phase word width (full scale = 2*pi)
    localparam int c_phase_width_dflt = 16;

    typedef logic [c_phase_width_dflt-1:0] phase_t;

    // Phase accumulator FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Total number of qubits served across all drive banks
    function automatic int f_total_qubit(input int num_bank, input int num_qubit_per_bank);
        return num_bank * num_qubit_per_bank;
    endfunction

    // Left shift that places a correction field in the top bits of the phase word
    function automatic int f_shift_amt(input int phase_width, input int z_corr_width);
        return phase_width - z_corr_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/drive_z_next_idx.sv
`default_nettype none
// ============================================================================
// Module      : drive_z_next_idx
// Description : Combinational priority search for the lowest qubit index at or
//               above a start index whose correction field is nonzero.
// Revision    : 1.0 - initial release
// ============================================================================
module drive_z_next_idx
    import drive_pkg::*;
#(
    parameter int TOTAL_QUBIT  = 4,
    parameter int Z_CORR_WIDTH = 4,
    parameter int ADDR_WIDTH   = 2
) (
    input  logic [Z_CORR_WIDTH*TOTAL_QUBIT-1:0] i_vec,
    input  logic [ADDR_WIDTH:0]                 i_start,
    output logic                                o_found,
    output logic [ADDR_WIDTH-1:0]               o_idx
);

    // Scan from the top down so the lowest qualifying index wins
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = TOTAL_QUBIT - 1; i >= 0; i--) begin
            if (((ADDR_WIDTH+1)'(i) >= i_start) && (|i_vec[i*Z_CORR_WIDTH +: Z_CORR_WIDTH])) begin
                o_found = 1'b1;
                o_idx   = ADDR_WIDTH'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/drive_z_phase_accum.sv
`default_nettype none
// ============================================================================
// Module      : drive_z_phase_accum
// Description : Per-qubit virtual-Z phase accumulator. Captures one packed
//               correction vector per handshake and adds each qubit's field
//               (MSB-aligned, modular) into its phase register, one qubit per
//               cycle through a single adder. Registered write-first read port.
//               Optional macro DRIVE_Z_PHASE_SKIP_ZERO_EN: skip qubits whose
//               field is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module drive_z_phase_accum
    import drive_pkg::*;
#(
    parameter int NUM_BANK           = 2,
    parameter int NUM_QUBIT_PER_BANK = 2,
    parameter int Z_CORR_WIDTH       = 4,
    parameter int PHASE_WIDTH        = 16,
    parameter int QUBIT_ADDR_WIDTH   = 2
) (
    input  logic                                                             clk,
    input  logic                                                             rst,
    input  logic [Z_CORR_WIDTH*f_total_qubit(NUM_BANK,NUM_QUBIT_PER_BANK)-1:0] z_corr_in,
    input  logic                                                             z_corr_valid,
    output logic                                                             z_corr_ready,
    input  logic                                                             phase_clr,
    input  logic [QUBIT_ADDR_WIDTH-1:0]                                      phase_rd_addr,
    output logic [PHASE_WIDTH-1:0]                                           phase_rd_data,
    output logic                                                             update_done
);

    localparam int c_total_qubit = f_total_qubit(NUM_BANK, NUM_QUBIT_PER_BANK);
    localparam int c_shift       = f_shift_amt(PHASE_WIDTH, Z_CORR_WIDTH);
    localparam int c_vec_w       = Z_CORR_WIDTH * c_total_qubit;
    localparam int c_rd_depth    = 2 ** QUBIT_ADDR_WIDTH;
    localparam logic [QUBIT_ADDR_WIDTH-1:0] c_last_idx = QUBIT_ADDR_WIDTH'(c_total_qubit - 1);

    state_t                      r_state;
    logic [QUBIT_ADDR_WIDTH-1:0] r_idx;
    logic [c_vec_w-1:0]          r_shadow;
    logic                        r_ready;
    logic                        r_done;
    logic [PHASE_WIDTH-1:0]      r_phase     [c_total_qubit];
    logic [PHASE_WIDTH-1:0]      w_phase_nxt [c_total_qubit];
    logic [PHASE_WIDTH-1:0]      w_rd_vec    [c_rd_depth];
    logic [PHASE_WIDTH-1:0]      r_rd_data;
    logic [Z_CORR_WIDTH-1:0]     w_field;
    logic [PHASE_WIDTH-1:0]      w_sum;
    logic                        w_wr_en;

    // Single shared adder: current qubit's phase plus its MSB-aligned field
    assign w_field = r_shadow[r_idx*Z_CORR_WIDTH +: Z_CORR_WIDTH];
    assign w_sum   = r_phase[r_idx] + (PHASE_WIDTH'(w_field) << c_shift);
    assign w_wr_en = (r_state == ST_UPDATE) && !phase_clr;

    // Next value of every phase register; also feeds the write-first read mux
    for (genvar i = 0; i < c_total_qubit; i++) begin : g_phase_nxt
        assign w_phase_nxt[i] = phase_clr ? '0 :
                                (w_wr_en && (r_idx == QUBIT_ADDR_WIDTH'(i))) ? w_sum :
                                r_phase[i];
    end

    // Out-of-range read addresses map to zero
    for (genvar i = 0; i < c_rd_depth; i++) begin : g_rd_vec
        if (i < c_total_qubit) begin : g_valid
            assign w_rd_vec[i] = w_phase_nxt[i];
        end else begin : g_oob
            assign w_rd_vec[i] = '0;
        end
    end

`ifdef DRIVE_Z_PHASE_SKIP_ZERO_EN
    logic [c_vec_w-1:0]          w_srch_vec;
    logic [QUBIT_ADDR_WIDTH:0]   w_srch_start;
    logic                        w_nz_found;
    logic [QUBIT_ADDR_WIDTH-1:0] w_nz_idx;

    // In IDLE search the incoming vector from 0; in UPDATE search the shadow past idx
    assign w_srch_vec   = (r_state == ST_IDLE) ? z_corr_in : r_shadow;
    assign w_srch_start = (r_state == ST_IDLE) ? '0 : ({1'b0, r_idx} + 1'b1);

    drive_z_next_idx #(
        .TOTAL_QUBIT  (c_total_qubit),
        .Z_CORR_WIDTH (Z_CORR_WIDTH),
        .ADDR_WIDTH   (QUBIT_ADDR_WIDTH)
    ) u_next_idx (
        .i_vec   (w_srch_vec),
        .i_start (w_srch_start),
        .o_found (w_nz_found),
        .o_idx   (w_nz_idx)
    );
`endif

    // Phase registers: cleared by reset, otherwise take the computed next value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_total_qubit; i++) begin
                r_phase[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_total_qubit; i++) begin
                r_phase[i] <= w_phase_nxt[i];
            end
        end
    end

    // Registered read port showing the post-edge (write-first) phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_vec[phase_rd_addr];
        end
    end

    // Update sequencer with registered ready/done outputs; clear aborts everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_shadow <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
        end else if (phase_clr) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (z_corr_valid) begin
                        r_shadow <= z_corr_in;
                        r_ready  <= 1'b0;
`ifdef DRIVE_Z_PHASE_SKIP_ZERO_EN
                        if (w_nz_found) begin
                            r_idx   <= w_nz_idx;
                            r_state <= ST_UPDATE;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
`else
                        r_idx   <= '0;
                        r_state <= ST_UPDATE;
`endif
                    end
                end
                ST_UPDATE: begin
`ifdef DRIVE_Z_PHASE_SKIP_ZERO_EN
                    if (w_nz_found) begin
                        r_idx <= w_nz_idx;
                    end else begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
`else
                    if (r_idx == c_last_idx) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign z_corr_ready  = r_ready;
    assign update_done   = r_done;
    assign phase_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_drive_z_phase_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_drive_z_phase_accum
// Description : Directed self-checking bench for drive_z_phase_accum with
//               hand-computed expected phases and handshake timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_drive_z_phase_accum;
    import drive_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] z_corr_in = '0;
    logic        z_corr_valid = 1'b0;
    logic        z_corr_ready;
    logic        phase_clr = 1'b0;
    logic [1:0]  phase_rd_addr = '0;
    phase_t      phase_rd_data;
    logic        update_done;

    int vectors     = 0;
    int miscompares = 0;

    drive_z_phase_accum #(
        .NUM_BANK           (2),
        .NUM_QUBIT_PER_BANK (2),
        .Z_CORR_WIDTH       (4),
        .PHASE_WIDTH        (16),
        .QUBIT_ADDR_WIDTH   (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .z_corr_in     (z_corr_in),
        .z_corr_valid  (z_corr_valid),
        .z_corr_ready  (z_corr_ready),
        .phase_clr     (phase_clr),
        .phase_rd_addr (phase_rd_addr),
        .phase_rd_data (phase_rd_data),
        .update_done   (update_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycles from handshake edge to the update_done cycle
    function automatic int lat_of(input logic [15:0] v);
`ifdef DRIVE_Z_PHASE_SKIP_ZERO_EN
        int n = 0;
        for (int q = 0; q < 4; q++) begin
            if (v[q*4 +: 4] != 4'h0) n++;
        end
        return n + 1;
`else
        return 5;
`endif
    endfunction

    task automatic read_all(input string tag, input logic [63:0] exp);
        for (int a = 0; a < 4; a++) begin
            @(negedge clk);
            phase_rd_addr = 2'(a);
            @(posedge clk);
            #1;
            check($sformatf("%s_rd%0d", tag, a), phase_rd_data, exp[a*16 +: 16]);
        end
    endtask

    task automatic send(input string tag, input logic [15:0] v);
        int lat;
        @(negedge clk);
        check({tag, "_ready_pre"}, z_corr_ready, 1);
        z_corr_in    = v;
        z_corr_valid = 1'b1;
        @(posedge clk);
        #1;
        z_corr_valid = 1'b0;
        lat = lat_of(v);
        for (int k = 1; k <= lat + 1; k++) begin
            check($sformatf("%s_done_T%0d", tag, k), update_done, (k == lat) ? 1 : 0);
            check($sformatf("%s_ready_T%0d", tag, k), z_corr_ready, (k == lat + 1) ? 1 : 0);
            if (k <= lat) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", z_corr_ready, 1);
        check("rst_done", update_done, 0);
        check("rst_rd", phase_rd_data, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        read_all("post_rst", 64'h0000_0000_0000_0000);
        check("idle_ready", z_corr_ready, 1);

        // Basic accumulate and modular wrap
        send("v9999a", 16'h9999);
        read_all("after9999", 64'h9000_9000_9000_9000);
        send("v9999b", 16'h9999);
        read_all("wrap", 64'h2000_2000_2000_2000);
        send("v8888", 16'h8888);
        read_all("after8888", 64'hA000_A000_A000_A000);

        // Clear while idle
        @(negedge clk);
        phase_clr = 1'b1;
        @(negedge clk);
        phase_clr = 1'b0;
        read_all("clr_idle", 64'h0000_0000_0000_0000);

        // Distinct per-qubit fields, then modular negative add on qubit 0
        send("v4320", 16'h4320);
        read_all("after4320", 64'h4000_3000_2000_0000);
        send("v0001", 16'h0001);
        read_all("after0001", 64'h4000_3000_2000_1000);
        send("v000F", 16'h000F);
        read_all("after000F", 64'h4000_3000_2000_0000);

        // Zero vector and single nonzero field
        send("v0000", 16'h0000);
        read_all("after0000", 64'h4000_3000_2000_0000);
        send("v0300", 16'h0300);
        read_all("after0300", 64'h4000_6000_2000_0000);

        // Clear mid-update with valid held high
        @(negedge clk);
        phase_clr = 1'b1;
        @(negedge clk);
        phase_clr = 1'b0;
        z_corr_in     = 16'h1111;
        z_corr_valid  = 1'b1;
        phase_rd_addr = 2'd0;
        @(posedge clk);               // edge T: handshake
        #1;
        check("clr_upd_ready_T1", z_corr_ready, 0);
        @(posedge clk);               // edge T+1: qubit 0 written
        #1;
        check("wr_first_rd0", phase_rd_data, 16'h1000);
        @(negedge clk);
        phase_clr = 1'b1;
        @(posedge clk);               // edge T+2: clear aborts update
        #1;
        check("clr_upd_ready_T3", z_corr_ready, 1);
        check("clr_upd_done_T3", update_done, 0);
        check("clr_upd_rd0", phase_rd_data, 16'h0000);
        @(posedge clk);               // edge T+3: clear beats handshake
        #1;
        check("clr_prio_ready", z_corr_ready, 1);
        check("clr_prio_done", update_done, 0);
        @(negedge clk);
        phase_clr    = 1'b0;
        z_corr_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("clr_quiet_done%0d", k), update_done, 0);
            check($sformatf("clr_quiet_ready%0d", k), z_corr_ready, 1);
        end
        read_all("after_clr_upd", 64'h0000_0000_0000_0000);

        // Reset mid-update discards partial progress
        @(negedge clk);
        z_corr_in    = 16'h1111;
        z_corr_valid = 1'b1;
        @(posedge clk);
        #1;
        z_corr_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_ready", z_corr_ready, 1);
        check("rst_mid_done", update_done, 0);
        check("rst_mid_rd", phase_rd_data, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        read_all("after_rst_mid", 64'h0000_0000_0000_0000);
        send("v1111", 16'h1111);
        read_all("after1111", 64'h1000_1000_1000_1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
